// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX/MEM pipeline register with Z/N/V flags, stall, flush and sticky halt (optional EX_MEM_PERF_CNT_EN counters)
module ex_mem_pipe_reg #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_alu_result,
    input  logic          in_ovfl,
    input  logic [1:0]    in_flag_mode,
    input  logic [DW-1:0] in_store_data,
    input  logic [RW-1:0] in_dst_reg,
    input  logic          in_reg_write,
    input  logic          in_mem_read,
    input  logic          in_mem_write,
    input  logic          in_halt,
    output logic          out_valid,
    output logic [DW-1:0] out_alu_result,
    output logic [DW-1:0] out_store_data,
    output logic [RW-1:0] out_dst_reg,
    output logic          out_reg_write,
    output logic          out_mem_read,
    output logic          out_mem_write,
    output logic          out_halt,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_v,
`ifdef EX_MEM_PERF_CNT_EN
    output logic [15:0]   perf_inst_cnt,
    output logic [15:0]   perf_stall_cnt,
`endif
    output logic          halted
);

    localparam logic [1:0] FM_Z   = 2'b01;
    localparam logic [1:0] FM_ZNV = 2'b10;

    logic          valid_q;
    logic [DW-1:0] alu_q;
    logic [DW-1:0] store_q;
    logic [RW-1:0] dst_q;
    logic          rw_q;
    logic          mr_q;
    logic          mw_q;
    logic          halt_q;
    logic          z_q;
    logic          n_q;
    logic          v_q;
    logic          halted_q;
    logic          acc;
    logic          bubble;

    assign acc    = in_valid & ~flush & ~stall & ~halted_q;
    // Flush beats stall; an empty EX slot without stall also becomes a bubble.
    assign bubble = flush | (~stall & ~in_valid);

    // Stage register and flags: reset, then halt freeze, bubble, stall hold, accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            alu_q    <= '0;
            store_q  <= '0;
            dst_q    <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            halt_q   <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            halted_q <= 1'b0;
        end else if (halted_q) begin
            valid_q <= valid_q;
        end else if (bubble) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else if (acc) begin
            valid_q  <= 1'b1;
            alu_q    <= in_alu_result;
            store_q  <= in_store_data;
            dst_q    <= in_dst_reg;
            rw_q     <= in_reg_write & ~in_halt;
            mr_q     <= in_mem_read & ~in_halt;
            mw_q     <= in_mem_write & ~in_halt;
            halt_q   <= in_halt;
            halted_q <= in_halt;
            if (in_flag_mode == FM_ZNV) begin
                z_q <= (in_alu_result == '0);
                n_q <= in_alu_result[DW-1];
                v_q <= in_ovfl;
            end else if (in_flag_mode == FM_Z) begin
                z_q <= (in_alu_result == '0);
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_alu_result = alu_q;
    assign out_store_data = store_q;
    assign out_dst_reg    = dst_q;
    assign out_reg_write  = valid_q & rw_q;
    assign out_mem_read   = valid_q & mr_q;
    assign out_mem_write  = valid_q & mw_q;
    assign out_halt       = valid_q & halt_q;
    assign flag_z         = z_q;
    assign flag_n         = n_q;
    assign flag_v         = v_q;
    assign halted         = halted_q;

`ifdef EX_MEM_PERF_CNT_EN
    logic [15:0] inst_cnt_q;
    logic [15:0] stall_cnt_q;

    // Saturating instruction and stall-cycle counters, frozen while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (!halted_q) begin
            if (acc && inst_cnt_q != 16'hFFFF)
                inst_cnt_q <= inst_cnt_q + 16'd1;
            if (stall && !flush && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign perf_inst_cnt  = inst_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
